// File: rtl/datapath_ctrl_if.sv
// Bundle between the instruction-sequencing controller and the 16-bit datapath.
// The master side is the controller: it takes start/instr and drives every
// datapath strobe and select. The slave side is the instruction source plus datapath.
interface datapath_ctrl_if #(
    parameter int DW = 16,
    parameter int RW = 3
);
    logic          start;
    logic [15:0]   instr;
    logic          w;
    logic [DW-1:0] datapath_in;
    logic          vsel;
    logic          write;
    logic          loada;
    logic          loadb;
    logic          asel;
    logic          bsel;
    logic          loadc;
    logic          loads;
    logic [RW-1:0] readnum;
    logic [RW-1:0] writenum;
    logic [1:0]    shift;
    logic [1:0]    ALUop;

    modport master (
        input  start, instr,
        output w, datapath_in, vsel, write, loada, loadb, asel, bsel,
               loadc, loads, readnum, writenum, shift, ALUop
    );

    modport slave (
        output start, instr,
        input  w, datapath_in, vsel, write, loada, loadb, asel, bsel,
               loadc, loads, readnum, writenum, shift, ALUop
    );
endinterface

// File: rtl/datapath_ctrl.sv
// Instruction sequencer for the 16-bit datapath (regfile, A/B/C, shifter, ALU, Z).
// One instruction is taken per start handshake in WAIT and stepped through the
// datapath with Moore outputs decoded from state and the held instruction register.
// Build option ILLEGAL_TRAP_EN: an illegal opcode parks the FSM in HALT until reset;
// without it an illegal opcode behaves as a NOP and returns to WAIT.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// WAIT     | idle, w=1, instruction captured on start
// DECODE   | classify opcode/op, no strobes
// GET_A    | read Rn into A
// GET_B    | read Rm into B
// ALU      | shift B, run ALU, load C (or status Z for CMP)
// WR_IMM   | write sign-extended imm8 to Rn
// WR_REG   | write C to Rd
// HALT     | illegal-opcode trap (trap build only), left only by reset
module datapath_ctrl #(
    parameter int DW = 16,
    parameter int RW = 3
) (
    input logic           clk,
    input logic           rst_n,
    datapath_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_GET_A  = 3'd2,
        S_GET_B  = 3'd3,
        S_ALU    = 3'd4,
        S_WR_IMM = 3'd5,
        S_WR_REG = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    state_t state;
    state_t state_nx;
    logic [15:0] ir;

    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [1:0] sh;
    logic [2:0] rm;

    logic          w_c;
    logic          vsel_c;
    logic          write_c;
    logic          loada_c;
    logic          loadb_c;
    logic          asel_c;
    logic          bsel_c;
    logic          loadc_c;
    logic          loads_c;
    logic [RW-1:0] readnum_c;
    logic [RW-1:0] writenum_c;
    logic [1:0]    shift_c;
    logic [1:0]    aluop_c;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];

    // State register and instruction capture; IR only moves on an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_WAIT;
            ir    <= '0;
        end else begin
            state <= state_nx;
            if (state == S_WAIT && bus.start) begin
                ir <= bus.instr;
            end
        end
    end

    // Next-state and Moore output decode; every strobe defaults low.
    always_comb begin
        state_nx   = state;
        w_c        = 1'b0;
        vsel_c     = 1'b0;
        write_c    = 1'b0;
        loada_c    = 1'b0;
        loadb_c    = 1'b0;
        asel_c     = 1'b0;
        bsel_c     = 1'b0;
        loadc_c    = 1'b0;
        loads_c    = 1'b0;
        readnum_c  = '0;
        writenum_c = '0;
        shift_c    = 2'b00;
        aluop_c    = 2'b00;
        case (state)
            S_WAIT: begin
                w_c = 1'b1;
                if (bus.start) begin
                    state_nx = S_DECODE;
                end
            end
            S_DECODE: begin
                case ({opcode, op})
                    5'b110_10:                     state_nx = S_WR_IMM;
                    5'b110_00:                     state_nx = S_GET_B;
                    5'b101_00, 5'b101_01, 5'b101_10: state_nx = S_GET_A;
                    5'b101_11:                     state_nx = S_GET_B;
`ifdef ILLEGAL_TRAP_EN
                    default:                       state_nx = S_HALT;
`else
                    default:                       state_nx = S_WAIT;
`endif
                endcase
            end
            S_GET_A: begin
                readnum_c = RW'(rn);
                loada_c   = 1'b1;
                state_nx  = S_GET_B;
            end
            S_GET_B: begin
                readnum_c = RW'(rm);
                loadb_c   = 1'b1;
                state_nx  = S_ALU;
            end
            S_ALU: begin
                shift_c = sh;
                if (opcode == 3'b110) begin
                    // MOV reg: A path forced to zero so C = 0 + shifted B
                    asel_c   = 1'b1;
                    loadc_c  = 1'b1;
                    state_nx = S_WR_REG;
                end else if (op == 2'b01) begin
                    // CMP only updates status; C and the regfile stay untouched
                    aluop_c  = 2'b01;
                    loads_c  = 1'b1;
                    state_nx = S_WAIT;
                end else begin
                    aluop_c  = op;
                    asel_c   = (op == 2'b11);
                    loadc_c  = 1'b1;
                    state_nx = S_WR_REG;
                end
            end
            S_WR_IMM: begin
                vsel_c     = 1'b1;
                writenum_c = RW'(rn);
                write_c    = 1'b1;
                state_nx   = S_WAIT;
            end
            S_WR_REG: begin
                writenum_c = RW'(rd);
                write_c    = 1'b1;
                state_nx   = S_WAIT;
            end
`ifdef ILLEGAL_TRAP_EN
            S_HALT: begin
                state_nx = S_HALT;
            end
`endif
            default: begin
                state_nx = S_WAIT;
            end
        endcase
    end

    assign bus.w           = w_c;
    assign bus.vsel        = vsel_c;
    assign bus.write       = write_c;
    assign bus.loada       = loada_c;
    assign bus.loadb       = loadb_c;
    assign bus.asel        = asel_c;
    assign bus.bsel        = bsel_c;
    assign bus.loadc       = loadc_c;
    assign bus.loads       = loads_c;
    assign bus.readnum     = readnum_c;
    assign bus.writenum    = writenum_c;
    assign bus.shift       = shift_c;
    assign bus.ALUop       = aluop_c;
    assign bus.datapath_in = {{(DW-8){ir[7]}}, ir[7:0]};

endmodule

// File: tb/tb_datapath_ctrl.sv
// Bench for datapath_ctrl: directed instructions, hand-written per-cycle expected
// output snapshots pushed into a scoreboard queue, popped by an independent monitor.
module tb_datapath_ctrl;

    typedef struct packed {
        logic        w;
        logic        vsel;
        logic        write;
        logic        loada;
        logic        loadb;
        logic        asel;
        logic        bsel;
        logic        loadc;
        logic        loads;
        logic [2:0]  readnum;
        logic [2:0]  writenum;
        logic [1:0]  shift;
        logic [1:0]  aluop;
        logic [15:0] dpin;
    } snap_t;

    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    snap_t q_exp[$];
    string q_name[$];

    datapath_ctrl_if #(.DW(16), .RW(3)) bus ();

    datapath_ctrl #(.DW(16), .RW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic snap_t actual();
        snap_t s;
        s.w        = bus.w;
        s.vsel     = bus.vsel;
        s.write    = bus.write;
        s.loada    = bus.loada;
        s.loadb    = bus.loadb;
        s.asel     = bus.asel;
        s.bsel     = bus.bsel;
        s.loadc    = bus.loadc;
        s.loads    = bus.loads;
        s.readnum  = bus.readnum;
        s.writenum = bus.writenum;
        s.shift    = bus.shift;
        s.aluop    = bus.ALUop;
        s.dpin     = bus.datapath_in;
        return s;
    endfunction

    function automatic snap_t busy(input logic [15:0] d);
        snap_t s;
        s = '0;
        s.dpin = d;
        return s;
    endfunction

    function automatic snap_t idle(input logic [15:0] d);
        snap_t s;
        s = '0;
        s.w = 1'b1;
        s.dpin = d;
        return s;
    endfunction

    task automatic push(input snap_t s, input string name);
        q_exp.push_back(s);
        q_name.push_back(name);
    endtask

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: one snapshot per cycle, sampled after the edge has settled.
    initial begin
        snap_t e;
        snap_t a;
        string n;
        forever begin
            @(posedge clk);
            #2;
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                n = q_name.pop_front();
                a = actual();
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s actual=%h expected=%h", n, a, e);
                end
            end
        end
    end

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q_exp.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (q_exp.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout pending=%0d expected=0", name, q_exp.size());
            q_exp.delete();
            q_name.delete();
        end
    endtask

    // Drive one instruction for a single cycle, then scramble instr to prove IR holds.
    task automatic accept(input logic [15:0] ins);
        @(negedge clk);
        bus.start = 1'b1;
        bus.instr = ins;
    endtask

    task automatic release_start();
        @(negedge clk);
        bus.start = 1'b0;
        bus.instr = 16'hFFFF;
    endtask

    initial begin
        snap_t s;
        bus.start = 1'b0;
        bus.instr = 16'h0000;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        s = idle(16'h0000);
        check(actual() === s, "reset_state", 32'(actual()), 32'(s));
        rst_n = 1'b1;
        @(negedge clk);

        // MOV R2,#-5
        accept(16'hD2FB);
        push(busy(16'hFFFB), "movimm_decode");
        s = busy(16'hFFFB); s.vsel = 1; s.writenum = 3'd2; s.write = 1;
        push(s, "movimm_wr_imm");
        push(idle(16'hFFFB), "movimm_wait");
        release_start();
        drain("movimm");

        // ADD R3,R1,R2,LSL#1
        accept(16'hA16A);
        push(busy(16'h006A), "add_decode");
        s = busy(16'h006A); s.readnum = 3'd1; s.loada = 1; push(s, "add_get_a");
        s = busy(16'h006A); s.readnum = 3'd2; s.loadb = 1; push(s, "add_get_b");
        s = busy(16'h006A); s.shift = 2'b01; s.loadc = 1; push(s, "add_alu");
        s = busy(16'h006A); s.writenum = 3'd3; s.write = 1; push(s, "add_wr_reg");
        push(idle(16'h006A), "add_wait");
        release_start();
        drain("add");

        // CMP R1,R1
        accept(16'hA901);
        push(busy(16'h0001), "cmp_decode");
        s = busy(16'h0001); s.readnum = 3'd1; s.loada = 1; push(s, "cmp_get_a");
        s = busy(16'h0001); s.readnum = 3'd1; s.loadb = 1; push(s, "cmp_get_b");
        s = busy(16'h0001); s.aluop = 2'b01; s.loads = 1; push(s, "cmp_alu");
        push(idle(16'h0001), "cmp_wait");
        release_start();
        drain("cmp");

        // MOV R5,R3,LSR#1
        accept(16'hC0B3);
        push(busy(16'hFFB3), "movreg_decode");
        s = busy(16'hFFB3); s.readnum = 3'd3; s.loadb = 1; push(s, "movreg_get_b");
        s = busy(16'hFFB3); s.shift = 2'b10; s.asel = 1; s.loadc = 1; push(s, "movreg_alu");
        s = busy(16'hFFB3); s.writenum = 3'd5; s.write = 1; push(s, "movreg_wr_reg");
        push(idle(16'hFFB3), "movreg_wait");
        release_start();
        drain("movreg");

        // AND R4,R6,R7
        accept(16'hB687);
        push(busy(16'hFF87), "and_decode");
        s = busy(16'hFF87); s.readnum = 3'd6; s.loada = 1; push(s, "and_get_a");
        s = busy(16'hFF87); s.readnum = 3'd7; s.loadb = 1; push(s, "and_get_b");
        s = busy(16'hFF87); s.aluop = 2'b10; s.loadc = 1; push(s, "and_alu");
        s = busy(16'hFF87); s.writenum = 3'd4; s.write = 1; push(s, "and_wr_reg");
        push(idle(16'hFF87), "and_wait");
        release_start();
        drain("and");

        // MVN R1,R2,ASR
        accept(16'hB83A);
        push(busy(16'h003A), "mvn_decode");
        s = busy(16'h003A); s.readnum = 3'd2; s.loadb = 1; push(s, "mvn_get_b");
        s = busy(16'h003A); s.shift = 2'b11; s.aluop = 2'b11; s.asel = 1; s.loadc = 1; push(s, "mvn_alu");
        s = busy(16'h003A); s.writenum = 3'd1; s.write = 1; push(s, "mvn_wr_reg");
        push(idle(16'h003A), "mvn_wait");
        release_start();
        drain("mvn");

        // ADD again with a MOV R0,#-1 start pulse landing mid-instruction
        accept(16'hA16A);
        push(busy(16'h006A), "ign_decode");
        s = busy(16'h006A); s.readnum = 3'd1; s.loada = 1; push(s, "ign_get_a");
        s = busy(16'h006A); s.readnum = 3'd2; s.loadb = 1; push(s, "ign_get_b");
        s = busy(16'h006A); s.shift = 2'b01; s.loadc = 1; push(s, "ign_alu");
        s = busy(16'h006A); s.writenum = 3'd3; s.write = 1; push(s, "ign_wr_reg");
        push(idle(16'h006A), "ign_wait");
        release_start();
        @(negedge clk);
        bus.start = 1'b1;
        bus.instr = 16'hD0FF;
        @(negedge clk);
        bus.start = 1'b0;
        bus.instr = 16'h0000;
        drain("ignored_start");

        // Back-to-back MOV R1,#1 with start held high
        accept(16'hD101);
        push(busy(16'h0001), "b2b_decode0");
        s = busy(16'h0001); s.vsel = 1; s.writenum = 3'd1; s.write = 1;
        push(s, "b2b_wr_imm0");
        push(idle(16'h0001), "b2b_wait0");
        push(busy(16'h0001), "b2b_decode1");
        push(s, "b2b_wr_imm1");
        push(idle(16'h0001), "b2b_wait1");
        repeat (4) @(negedge clk);
        bus.start = 1'b0;
        drain("back_to_back");

        // Illegal opcode 111
        accept(16'hE000);
        push(busy(16'h0000), "ill_decode");
`ifdef ILLEGAL_TRAP_EN
        push(busy(16'h0000), "ill_halt0");
        push(busy(16'h0000), "ill_halt1");
        push(busy(16'h0000), "ill_halt2");
        push(busy(16'h0000), "ill_halt3");
        release_start();
        drain("illegal_trap");
        rst_n = 1'b0;
        #1;
        check(bus.w === 1'b1, "halt_reset_w", 32'(bus.w), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
`else
        // accepting edge plus one more edge returns to WAIT
        push(idle(16'h0000), "ill_wait");
        push(idle(16'h0000), "ill_wait_hold");
        release_start();
        drain("illegal_nop");
`endif

        // Asynchronous reset while in the ALU cycle of an ADD
        accept(16'hA16A);
        release_start();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check(bus.loadc === 1'b1, "pre_reset_alu_loadc", 32'(bus.loadc), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check(bus.w === 1'b1, "async_reset_w", 32'(bus.w), 32'd1);
        check(bus.write === 1'b0, "async_reset_write", 32'(bus.write), 32'd0);
        check(bus.loadc === 1'b0, "async_reset_loadc", 32'(bus.loadc), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check(bus.datapath_in === 16'h0000, "reset_ir_clear", 32'(bus.datapath_in), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check(bus.write === 1'b0 && bus.w === 1'b1, "post_reset_idle",
                  {30'd0, bus.write, bus.w}, 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
